// File: rtl/sw_led_ctrl.sv
// Switch-to-RGB-LED controller: per-channel 2-flop sync, counter debounce,
// rising-edge driven toggle/colour state, and a registered active-low LED stage.
module sw_led_ctrl #(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int BLINK_HALF      = 62500000
) (
    input  logic            clk_125,
    input  logic            rst,
    input  logic [N_CH-1:0] sw,
    input  logic [1:0]      mode,
    output logic [N_CH-1:0] led_r_n,
    output logic [N_CH-1:0] led_g_n,
    output logic [N_CH-1:0] led_b_n,
    output logic [N_CH-1:0] db_out
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BC_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BC_W-1:0]  BC_MAX  = BC_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        COL_RED   = 2'd0,
        COL_GREEN = 2'd1,
        COL_BLUE  = 2'd2
    } col_t;

    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [N_CH-1:0] r_db;
    logic [N_CH-1:0] r_db_q;
    logic [N_CH-1:0] r_tg;
    logic [N_CH-1:0] r_led_r;
    logic [N_CH-1:0] r_led_g;
    logic [N_CH-1:0] r_led_b;
    logic [N_CH-1:0] w_rise;
    logic [BC_W-1:0] r_bc;
    logic            r_ph;

    assign w_rise  = r_db & ~r_db_q;
    assign led_r_n = r_led_r;
    assign led_g_n = r_led_g;
    assign led_b_n = r_led_b;
    assign db_out  = r_db;

    always_ff @(posedge clk_125) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db_q  <= '0;
            r_bc    <= '0;
            r_ph    <= 1'b0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            if (r_bc == BC_MAX) begin
                r_bc <= '0;
                r_ph <= ~r_ph;
            end else begin
                r_bc <= r_bc + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            col_t             r_col;
            col_t             w_lit;
            logic             w_r;
            logic             w_g;
            logic             w_b;

            always_ff @(posedge clk_125) begin
                if (rst) begin
                    r_cnt    <= '0;
                    r_db[gi] <= 1'b0;
                    r_tg[gi] <= 1'b0;
                    r_col    <= COL_RED;
                end else begin
                    if (r_sync2[gi] == r_db[gi]) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_db[gi] <= r_sync2[gi];
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_rise[gi]) begin
                        r_tg[gi] <= ~r_tg[gi];
                        case (r_col)
                            COL_RED:   r_col <= COL_GREEN;
                            COL_GREEN: r_col <= COL_BLUE;
                            default:   r_col <= COL_RED;
                        endcase
                    end
                end
            end

            // r_col already points at the next press's colour once the rise
            // has been consumed, so the held colour is its predecessor.
            always_comb begin
                w_lit = r_col;
                if (!w_rise[gi]) begin
                    case (r_col)
                        COL_RED:   w_lit = COL_BLUE;
                        COL_GREEN: w_lit = COL_RED;
                        default:   w_lit = COL_GREEN;
                    endcase
                end
            end

            always_comb begin
                w_r = 1'b1;
                w_g = 1'b1;
                w_b = 1'b1;
                case (mode)
                    2'b00: w_b = ~r_db[gi];
                    2'b01: w_b = ~r_tg[gi];
                    2'b10: w_b = ~(r_db[gi] & r_ph);
                    default: begin
                        if (r_db[gi]) begin
                            case (w_lit)
                                COL_RED:   w_r = 1'b0;
                                COL_GREEN: w_g = 1'b0;
                                default:   w_b = 1'b0;
                            endcase
                        end
                    end
                endcase
            end

            always_ff @(posedge clk_125) begin
                if (rst) begin
                    r_led_r[gi] <= 1'b1;
                    r_led_g[gi] <= 1'b1;
                    r_led_b[gi] <= 1'b1;
                end else begin
                    r_led_r[gi] <= w_r;
                    r_led_g[gi] <= w_g;
                    r_led_b[gi] <= w_b;
                end
            end
        end
    endgenerate

endmodule
